vj_tx_arbiter: RTL and testbench
================================

// Module: vj_tx_arbiter
// PURPOSE
//  Shares the single byte-wide transmit channel of DE0_Comm (UART TX / virtual-JTAG
//  shifter) between NUM_REQ on-chip requesters. Grants are round-robin and packet-locked:
//  a winner keeps the channel until its last byte, or until it stalls past a timeout.
//  Sits between the requesters and the TX serializer, inside DE0_Comm.
// PARAMETERS
//  NUM_REQ    4    number of requesters (2..8)
//  DATA_W     8    byte width of the TX channel
//  TIMEOUT    255  consecutive granted-but-invalid cycles before forced release (>=1)
// PORTS
//  CLOCK_50     in   1               system clock, 50 MHz, single clock domain
//  areset_n     in   1               reset, synchronous, active-low
//  req_valid    in   NUM_REQ         per-requester byte valid
//  req_data     in   NUM_REQ*DATA_W  packed bytes, requester i at [i*DATA_W +: DATA_W]
//  req_last     in   NUM_REQ         marks final byte of requester's packet
//  req_ready    out  NUM_REQ         byte accepted from requester i this cycle
//  tx_valid     out  1               byte valid toward serializer
//  tx_data      out  DATA_W          byte toward serializer
//  tx_ready     in   1               serializer accepts byte this cycle
//  grant_id     out  $clog2(NUM_REQ) index of current owner (valid while busy)
//  busy         out  1               channel owned
//  timeout_evt  out  1               one-cycle pulse on forced release
// BEHAVIOUR
//  Reset (areset_n low at rising edge): state IDLE, rr_ptr=0, grant_id=0, busy=0,
//   timeout_evt=0, idle_cnt=0; req_ready=0, tx_valid=0 throughout reset.
//  Handshake: byte transfers when tx_valid && tx_ready; req_ready[i] = (state==GRANT) &&
//   grant_id==i && tx_ready. tx_valid/tx_data are a combinational mux of the owner's
//   req_valid/req_data in GRANT, 0 in IDLE. tx_data holds while tx_valid && !tx_ready.
//  FSM:
//   IDLE : if any req_valid -> pick first set bit scanning from rr_ptr upward (wrap at
//          NUM_REQ); register grant_id, busy=1 -> GRANT. No byte moves in IDLE
//          (arbitration latency 1 cycle from req_valid to tx_valid).
//   GRANT: transfer with req_last[grant_id]=1 -> release; rr_ptr=grant_id+1 (mod NUM_REQ),
//          busy=0 -> IDLE.
//          owner req_valid=0 -> idle_cnt++; req_valid=1 -> idle_cnt=0.
//          idle_cnt reaching TIMEOUT -> release as above, timeout_evt=1 for one cycle.
//  Back-to-back: release and new grant never share a cycle; min 1 IDLE cycle between
//   packets. Released owner has lowest priority in next arbitration.
//  Other requesters' req_valid/req_data are ignored while not owner; they must hold.
//  Owner dropping req_valid mid-packet is legal (grant held, timeout runs).
//  tx_ready with tx_valid=0: no effect. Last byte stalled by tx_ready=0: grant held.
//  idle_cnt saturates at TIMEOUT; width $clog2(TIMEOUT+1).
//  Reset mid-packet: grant dropped immediately, partial packet abandoned, rr_ptr=0.
// STRUCTURE
//  Shared package vj_uart_pkg: DATA_W default, FSM state enum {IDLE, GRANT}, idle counter
//   width function. Sub-module rr_pick (combinational round-robin priority select:
//   req vector + pointer -> one-hot + index), reusable by the RX side router.
// TESTING
//  1 Reset: hold areset_n=0 5 cycles with req_valid=4'b1111 -> req_ready=0, tx_valid=0,
//    busy=0; release -> requester 0 granted next cycle.
//  2 Round-robin: all 4 requesters send 1-byte packets (last=1), tx_ready=1 -> grant order
//    0,1,2,3,0; each byte on tx_data exactly once, 2 cycles per packet.
//  3 Packet lock: req1 sends 3-byte packet 0xA1,0xA2,0xA3 while req2 valid -> tx_data
//    A1,A2,A3 contiguous, req2 granted only after A3.
//  4 Backpressure: tx_ready low 10 cycles mid-packet -> tx_data stable, req_ready=0,
//    no byte lost/duplicated, idle_cnt stays 0.
//  5 Timeout (TIMEOUT=8): owner drops req_valid after byte 1 -> timeout_evt pulse
//    8 cycles later, busy=0, next requester granted.
//  6 Mid-packet reset: assert areset_n=0 during 2nd of 4 bytes -> outputs at reset values
//    next edge; after release, requester 0 wins regardless of previous owner.

Source files
------------

// File: rtl/vj_uart_pkg.sv
// Shared definitions for the DE0_Comm UART / virtual-JTAG datapath.
// Holds the default byte width, the TX arbiter FSM state type and the helper
// that sizes the arbiter's idle (stall) counter.
package vj_uart_pkg;

    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Bits needed to count 0..timeout inclusive (at least one bit).
    function automatic int unsigned idle_cnt_w(input int unsigned timeout);
        int unsigned w;
        w = (timeout < 1) ? 1 : $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/vj_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority select.
// Scans the request vector starting at ptr, upward with wrap-around, and
// returns the first set request as a one-hot vector and as an index.
// Ports:
//   req     in   N   request vector
//   ptr     in   IW  highest-priority position for this scan (must be < N)
//   onehot  out  N   one-hot winner, all zero when no request
//   idx     out  IW  winner index, zero when no request
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx
);

    logic          found;
    int unsigned   j;
    logic [IW-1:0] jj;

    // First set bit at or after ptr, wrapping once around the vector.
    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        j      = 0;
        jj     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            j = 32'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            jj = IW'(j);
            if (!found && req[jj]) begin
                found      = 1'b1;
                onehot[jj] = 1'b1;
                idx        = jj;
            end
        end
    end

endmodule

// File: rtl/vj_tx_arbiter.sv
// vj_tx_arbiter: shares the single byte-wide TX channel of DE0_Comm between
// NUM_REQ requesters. Round-robin, packet-locked grants; an owner that stalls
// for TIMEOUT consecutive cycles without a valid byte is forcibly released.
// Ports:
//   CLOCK_50     in   1               system clock
//   areset_n     in   1               synchronous active-low reset
//   req_valid    in   NUM_REQ         per-requester byte valid
//   req_data     in   NUM_REQ*DATA_W  packed bytes, requester i at [i*DATA_W +: DATA_W]
//   req_last     in   NUM_REQ         last byte of requester's packet
//   req_ready    out  NUM_REQ         byte accepted from requester i this cycle
//   tx_valid     out  1               byte valid toward serializer
//   tx_data      out  DATA_W          byte toward serializer
//   tx_ready     in   1               serializer accepts byte
//   grant_id     out  clog2(NUM_REQ)  current owner (valid while busy)
//   busy         out  1               channel owned
//   timeout_evt  out  1               one-cycle pulse on forced release
module vj_tx_arbiter
    import vj_uart_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                         CLOCK_50,
    input  logic                         areset_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         tx_valid,
    output logic [DATA_W-1:0]            tx_data,
    input  logic                         tx_ready,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy,
    output logic                         timeout_evt
);

    localparam int unsigned GW = $clog2(NUM_REQ);
    localparam int unsigned CW = idle_cnt_w(TIMEOUT);

    arb_state_t        state, state_nx;
    logic [GW-1:0]     rr_ptr, rr_nx, grant_nx, pick_idx, next_ptr;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [CW-1:0]     idle_cnt, idle_nx;
    logic              tevt_nx;
    logic              owner_valid, owner_last, xfer;
    logic [DATA_W-1:0] owner_data;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (GW)
    ) u_pick (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    // Select the current owner's byte lane.
    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_id == GW'(i)) begin
                owner_valid = req_valid[i];
                owner_last  = req_last[i];
                owner_data  = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Handshake outputs; forced low while reset is asserted.
    assign tx_valid = areset_n && (state == GRANT) && owner_valid;
    assign tx_data  = tx_valid ? owner_data : '0;
    assign xfer     = tx_valid && tx_ready;
    assign busy     = (state == GRANT);

    always_comb begin
        req_ready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = areset_n && (state == GRANT) && (grant_id == GW'(i)) && tx_ready;
        end
    end

    // Released owner drops to lowest priority.
    assign next_ptr = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + GW'(1);

    // Next-state and register-input logic.
    always_comb begin
        state_nx = state;
        grant_nx = grant_id;
        rr_nx    = rr_ptr;
        idle_nx  = idle_cnt;
        tevt_nx  = 1'b0;
        case (state)
            IDLE: begin
                idle_nx = '0;
                if (|pick_onehot) begin
                    grant_nx = pick_idx;
                    state_nx = GRANT;
                end
            end
            GRANT: begin
                if (xfer && owner_last) begin
                    state_nx = IDLE;
                    rr_nx    = next_ptr;
                    idle_nx  = '0;
                end else if (owner_valid) begin
                    idle_nx = '0;
                end else if (idle_cnt == CW'(TIMEOUT - 1)) begin
                    // This stalled cycle brings the count to TIMEOUT.
                    state_nx = IDLE;
                    rr_nx    = next_ptr;
                    idle_nx  = '0;
                    tevt_nx  = 1'b1;
                end else begin
                    idle_nx = idle_cnt + CW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and arbitration registers.
    always_ff @(posedge CLOCK_50) begin
        if (!areset_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant_id    <= '0;
            idle_cnt    <= '0;
            timeout_evt <= 1'b0;
        end else begin
            state       <= state_nx;
            rr_ptr      <= rr_nx;
            grant_id    <= grant_nx;
            idle_cnt    <= idle_nx;
            timeout_evt <= tevt_nx;
        end
    end

endmodule

// File: tb/tb_vj_tx_arbiter.sv
// Self-checking bench for vj_tx_arbiter: per-requester byte queues feed the
// DUT, expected bytes (owner, value, cycle gap) go to a scoreboard when loaded
// and are popped as the serializer side accepts them.
module tb_vj_tx_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 areset_n;
    logic [NR-1:0]        req_valid, req_last, req_ready;
    logic [NR*DW-1:0]     req_data;
    logic                 tx_valid, tx_ready, busy, timeout_evt;
    logic [DW-1:0]        tx_data;
    logic [1:0]           grant_id;

    vj_tx_arbiter #(
        .NUM_REQ (NR),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .CLOCK_50    (clk),
        .areset_n    (areset_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_evt (timeout_evt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Requester model: each requester presents its queue head until accepted.
    logic [8:0] mem [NR][32];
    int head [NR] = '{default: 0};
    int tail [NR];

    always_comb begin
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = head[i] < tail[i];
            {req_last[i], req_data[i*DW +: DW]} = mem[i][head[i][4:0]];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                head[i] <= head[i] + 1;
            end
        end
    end

    task automatic load(input int r, input logic [7:0] d, input logic l);
        mem[r][tail[r][4:0]] = {l, d};
        tail[r]++;
    endtask

    // Scoreboard: gap = cycles since previous accepted byte, 0 = not checked.
    typedef struct {
        int         id;
        logic [7:0] data;
        int         gap;
    } exp_t;
    exp_t sb[$];

    task automatic push(input int id, input logic [7:0] d, input int gap);
        exp_t e;
        e.id   = id;
        e.data = d;
        e.gap  = gap;
        sb.push_back(e);
    endtask

    int cyc = 0;
    int prev_cyc = -1;
    int n_xfer = 0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (tx_valid && tx_ready) begin
                n_xfer++;
                check_eq("sb_nonempty", 32'(sb.size() > 0), 32'(1));
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_eq("xfer_id", 32'(grant_id), 32'(e.id));
                    check_eq("xfer_data", 32'(tx_data), 32'(e.data));
                    check_eq("xfer_ready", 32'(req_ready), 32'(1) << e.id);
                    if (e.gap != 0) begin
                        check_eq("xfer_gap", 32'(cyc - prev_cyc), 32'(e.gap));
                    end
                end
                prev_cyc = cyc;
            end
        end
    end

    task automatic wait_drain(input string tag, input int max);
        for (int i = 0; i < max && sb.size() != 0; i++) begin
            @(posedge clk);
        end
        check_eq({"drain_", tag}, 32'(sb.size()), 32'(0));
        #1;
    endtask

    task automatic wait_xfers(input string tag, input int target, input int max);
        for (int i = 0; i < max && n_xfer < target; i++) begin
            @(posedge clk);
        end
        check_eq({"sync_", tag}, 32'(n_xfer), 32'(target));
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached got=%0t exp=<100000", $time);
        $fatal(1);
    end

    initial begin
        int base;
        int k;
        logic got;
        logic seen;

        for (int i = 0; i < NR; i++) begin
            tail[i] = 0;
            for (int j = 0; j < 32; j++) begin
                mem[i][j] = '0;
            end
        end
        areset_n = 1'b0;
        tx_ready = 1'b1;

        // Reset with all requesters valid, then round-robin of 1-byte packets.
        load(0, 8'h10, 1'b1);
        load(1, 8'h11, 1'b1);
        load(2, 8'h12, 1'b1);
        load(3, 8'h13, 1'b1);
        load(0, 8'h14, 1'b1);
        push(0, 8'h10, 0);
        push(1, 8'h11, 2);
        push(2, 8'h12, 2);
        push(3, 8'h13, 2);
        push(0, 8'h14, 2);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req_ready", 32'(req_ready), 32'(0));
        check_eq("rst_tx_valid", 32'(tx_valid), 32'(0));
        check_eq("rst_busy", 32'(busy), 32'(0));
        check_eq("rst_tevt", 32'(timeout_evt), 32'(0));
        check_eq("rst_gid", 32'(grant_id), 32'(0));
        @(posedge clk);
        #1 areset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("t1_busy", 32'(busy), 32'(1));
        check_eq("t1_gid", 32'(grant_id), 32'(0));
        wait_drain("rr", 100);

        // Packet lock: req1 3-byte packet while req2 waits.
        load(1, 8'hA1, 1'b0);
        load(1, 8'hA2, 1'b0);
        load(1, 8'hA3, 1'b1);
        load(2, 8'hB1, 1'b1);
        push(1, 8'hA1, 0);
        push(1, 8'hA2, 1);
        push(1, 8'hA3, 1);
        push(2, 8'hB1, 2);
        wait_drain("lock", 100);

        // Backpressure on the third byte for longer than the timeout.
        base = n_xfer;
        load(3, 8'hC1, 1'b0);
        load(3, 8'hC2, 1'b0);
        load(3, 8'hC3, 1'b0);
        load(3, 8'hC4, 1'b1);
        push(3, 8'hC1, 0);
        push(3, 8'hC2, 1);
        push(3, 8'hC3, 0);
        push(3, 8'hC4, 1);
        wait_xfers("bp", base + 2, 100);
        tx_ready = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check_eq("bp_data", 32'(tx_data), 32'(8'hC3));
            check_eq("bp_valid", 32'(tx_valid), 32'(1));
            check_eq("bp_ready", 32'(req_ready), 32'(0));
            check_eq("bp_tevt", 32'(timeout_evt), 32'(0));
            check_eq("bp_busy", 32'(busy), 32'(1));
        end
        @(posedge clk);
        #1 tx_ready = 1'b1;
        wait_drain("bp", 100);

        // Timeout: req0 sends one non-last byte then goes quiet.
        load(0, 8'hD1, 1'b0);
        load(1, 8'hE1, 1'b1);
        push(0, 8'hD1, 0);
        push(1, 8'hE1, 0);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = tx_valid && tx_ready;
        end
        check_eq("to_first_byte", 32'(got), 32'(1));
        k = 0;
        seen = 1'b0;
        for (int i = 1; i <= 3 * int'(TO) && !seen; i++) begin
            @(negedge clk);
            if (timeout_evt) begin
                seen = 1'b1;
                k = i;
            end
        end
        // Pulse is registered TIMEOUT edges after the transfer edge.
        check_eq("to_delay", 32'(k), 32'(TO + 1));
        check_eq("to_busy", 32'(busy), 32'(0));
        @(negedge clk);
        check_eq("to_pulse_end", 32'(timeout_evt), 32'(0));
        check_eq("to_regrant", 32'(busy), 32'(1));
        check_eq("to_gid", 32'(grant_id), 32'(1));
        wait_drain("to", 100);

        // Reset during the second byte of a 4-byte packet from req2.
        base = n_xfer;
        load(2, 8'hF1, 1'b0);
        load(2, 8'hF2, 1'b0);
        load(2, 8'hF3, 1'b0);
        load(2, 8'hF4, 1'b1);
        push(2, 8'hF1, 0);
        wait_xfers("mr", base + 1, 100);
        areset_n = 1'b0;
        @(negedge clk);
        check_eq("mr_tx_valid", 32'(tx_valid), 32'(0));
        check_eq("mr_req_ready", 32'(req_ready), 32'(0));
        load(0, 8'h61, 1'b1);
        load(1, 8'h71, 1'b1);
        push(0, 8'h61, 0);
        push(1, 8'h71, 2);
        push(2, 8'hF2, 2);
        push(2, 8'hF3, 1);
        push(2, 8'hF4, 1);
        @(posedge clk);
        @(negedge clk);
        check_eq("mr_busy", 32'(busy), 32'(0));
        check_eq("mr_gid", 32'(grant_id), 32'(0));
        check_eq("mr_tevt", 32'(timeout_evt), 32'(0));
        @(posedge clk);
        #1 areset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("mr_regrant_busy", 32'(busy), 32'(1));
        check_eq("mr_regrant_gid", 32'(grant_id), 32'(0));
        wait_drain("mr", 100);

        repeat (3) @(posedge clk);
        check_eq("sb_final", 32'(sb.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
